rx_unit: RTL and testbench
==========================

Name: rx_unit

Overview:
- Serial receive front end for the external memory interface.
- Detects message starts on rx_pins, decodes the type symbol, and counts payload cycles.
- Steers payload to the prefetcher (prefetch data) or the load path (load data).
- Tracks outstanding read/write requests issued by the TX side.
- Produces the rx_* strobes the prefetcher consumes. The strobes are aligned with live rx_pins so that consumers sample the pins in the same cycle.

Parameters:
- IO_BITS, 2, width of rx_pins and of each symbol.
- PAYLOAD_CYCLES, 8, data cycles per payload message (16 bits at IO_BITS=2).
- MAX_PENDING, 3, maximum number of outstanding requests.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rx_pins  in  IO_BITS  serial input symbols; idle value is all zeros.
- tx_request_issued  in  1  pulse: TX side has committed a request that expects a response.
- rx_started  out  1  start symbol seen this cycle.
- rx_active  out  1  message in progress (type or payload cycle).
- rx_sbs  out  IO_BITS  type symbol; equals rx_pins while rx_sbs_valid.
- rx_sbs_valid  out  1  current cycle is the type cycle.
- rx_data_valid  out  1  prefetch payload symbol on rx_pins this cycle.
- rx_load_valid  out  1  load payload symbol on rx_pins this cycle.
- rx_counter  out  $clog2(PAYLOAD_CYCLES)+1  payload cycle index.
- rx_done  out  1  last prefetch payload cycle.
- rx_load_done  out  1  last load payload cycle.
- rx_ack  out  1  write-ack message received (type cycle).
- rx_can_issue  out  1  number of pending requests is below MAX_PENDING.
- rx_error  out  1  sticky error flag.

Behaviour:
- States:
  - IDLE: a cycle where rx_pins != 0 is the start cycle. rx_started=1 (combinational from rx_pins) and the next state is TYPE.
  - TYPE: one cycle. rx_active=1, rx_sbs_valid=1, rx_sbs=rx_pins. Type decode:
    - 01: prefetch data, go to PAYLOAD_P.
    - 10: load data, go to PAYLOAD_L.
    - 11: write ack; rx_ack=1 this cycle, go to IDLE.
    - 00: set rx_error, go to IDLE.
  - PAYLOAD_P / PAYLOAD_L: PAYLOAD_CYCLES cycles.
    - rx_active=1; rx_data_valid (P) or rx_load_valid (L) is high every cycle.
    - rx_counter counts 0..PAYLOAD_CYCLES-1.
    - On the cycle with rx_counter==PAYLOAD_CYCLES-1: rx_done (P) or rx_load_done (L) is high in the same cycle as the last valid strobe, and the next state is IDLE.
- The header is always 2 cycles (start + type) before the first payload cycle.
- The start cycle's rx_pins value is ignored apart from the nonzero test.
- Back-to-back messages: a start may appear in the first IDLE cycle after a message ends. No guard cycle is required.
- rx_counter is 0 outside payload states and is cleared when entering a payload state.
- All strobe outputs are decoded from state/counter (plus rx_pins for rx_started and rx_sbs) and are never registered copies. Zero latency relative to rx_pins.
- Pending counter (width $clog2(MAX_PENDING+1)):
  - +1 on tx_request_issued.
  - -1 on rx_done, rx_load_done or rx_ack.
  - Simultaneous inc and dec leaves it unchanged.
  - rx_can_issue = pending < MAX_PENDING.
  - A response completing while pending==0 sets rx_error; pending stays 0 and the message is still delivered.
  - tx_request_issued while pending==MAX_PENDING sets rx_error and is ignored.
- rx_error is sticky until reset.
- Reset (synchronous, any state, including mid-payload):
  - state=IDLE, rx_counter=0, pending=0, rx_error=0.
  - All outputs low except rx_can_issue=1 and rx_sbs=0.
  - A partially received message is abandoned; nonzero rx_pins in the first cycle after reset is a new start.
- In TYPE and payload states rx_pins is never interpreted as a start symbol.

Test Plan:
- Reset, tx_request_issued once, drive 01 (start), 01 (type), then symbols 0,1,2,3,0,1,2,3 -> rx_sbs_valid on cycle 2; rx_data_valid cycles 3-10 with rx_counter 0..7; rx_done on cycle 10; pending 1->0; rx_error=0.
- Load message (type 10) immediately followed by a start in the next cycle -> rx_load_valid ×8, rx_load_done on the 8th, rx_started on the following cycle, no gap.
- Issue 3 requests -> rx_can_issue=0; a 4th pulse sets rx_error=1 and pending stays 3; a write ack (type 11) -> rx_ack=1 for one cycle, pending=2, rx_can_issue=1.
- Simultaneous tx_request_issued and rx_done with pending=1 -> pending stays 1, no error.
- Type 00 or a response with pending=0 -> rx_error=1, held until reset; the 0-pending payload is still strobed.
- Assert reset at payload cycle 4, then send a start in the first cycle after reset -> all outputs cleared; the new message decodes normally and rx_counter restarts at 0.

Source files
------------

// File: rtl/rx_unit_if.sv
// Receive-side bus between the serial pins and the prefetcher/load path consumers.
// slave is the receive front end; master is whatever drives the pins and watches the strobes.
interface rx_unit_if #(
    parameter int IO_BITS        = 2,
    parameter int PAYLOAD_CYCLES = 8
);
    localparam int CNT_W = $clog2(PAYLOAD_CYCLES) + 1;

    logic [IO_BITS-1:0] rx_pins;
    logic               tx_request_issued;
    logic               rx_started;
    logic               rx_active;
    logic [IO_BITS-1:0] rx_sbs;
    logic               rx_sbs_valid;
    logic               rx_data_valid;
    logic               rx_load_valid;
    logic [CNT_W-1:0]   rx_counter;
    logic               rx_done;
    logic               rx_load_done;
    logic               rx_ack;
    logic               rx_can_issue;
    logic               rx_error;

    modport slave (
        input  rx_pins, tx_request_issued,
        output rx_started, rx_active, rx_sbs, rx_sbs_valid, rx_data_valid, rx_load_valid,
               rx_counter, rx_done, rx_load_done, rx_ack, rx_can_issue, rx_error
    );

    modport master (
        output rx_pins, tx_request_issued,
        input  rx_started, rx_active, rx_sbs, rx_sbs_valid, rx_data_valid, rx_load_valid,
               rx_counter, rx_done, rx_load_done, rx_ack, rx_can_issue, rx_error
    );
endinterface

// File: rtl/rx_unit.sv
// Serial receive front end: start/type/payload framing, payload steering, outstanding-request tracking.
// Strobes are decoded combinationally from state and live rx_pins (zero latency); no backpressure, pins are always consumed.
module rx_unit #(
    parameter int IO_BITS        = 2,
    parameter int PAYLOAD_CYCLES = 8,
    parameter int MAX_PENDING    = 3
) (
    input  logic       clk,
    input  logic       reset,
    rx_unit_if.slave   bus
);
    localparam int CNT_W  = $clog2(PAYLOAD_CYCLES) + 1;
    localparam int PEND_W = $clog2(MAX_PENDING + 1);

    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(PAYLOAD_CYCLES - 1);
    localparam logic [PEND_W-1:0]  MAX_PEND = PEND_W'(MAX_PENDING);
    localparam logic [IO_BITS-1:0] SYM_PREF = IO_BITS'(1);
    localparam logic [IO_BITS-1:0] SYM_LOAD = IO_BITS'(2);
    localparam logic [IO_BITS-1:0] SYM_ACK  = IO_BITS'(3);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TYPE,
        ST_PAY_P,
        ST_PAY_L
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PEND_W-1:0]   pending_q, pending_d;
    logic                error_q, error_d;

    logic                pins_nz;
    logic                in_type;
    logic                in_pay_p;
    logic                in_pay_l;
    logic                last_cyc;
    logic                start_hit;
    logic                done_p;
    logic                done_l;
    logic                ack_hit;
    logic                type_bad;
    logic                rsp_done;
    logic                req_inc;

    // Raw decode from state, counter and live pins; reset gating is applied at the ports.
    always_comb begin
        pins_nz   = |bus.rx_pins;
        in_type   = (state_q == ST_TYPE);
        in_pay_p  = (state_q == ST_PAY_P);
        in_pay_l  = (state_q == ST_PAY_L);
        last_cyc  = (cnt_q == LAST_CNT);
        start_hit = (state_q == ST_IDLE) && pins_nz;
        done_p    = in_pay_p && last_cyc;
        done_l    = in_pay_l && last_cyc;
        ack_hit   = in_type && (bus.rx_pins == SYM_ACK);
        type_bad  = in_type && (bus.rx_pins != SYM_PREF) && (bus.rx_pins != SYM_LOAD)
                            && (bus.rx_pins != SYM_ACK);
        rsp_done  = done_p || done_l || ack_hit;
        req_inc   = bus.tx_request_issued;
    end

    // Frame sequencing: start -> type -> optional payload -> idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pins_nz) begin
                    state_d = ST_TYPE;
                end
            end
            ST_TYPE: begin
                cnt_d = '0;
                if (bus.rx_pins == SYM_PREF) begin
                    state_d = ST_PAY_P;
                end else if (bus.rx_pins == SYM_LOAD) begin
                    state_d = ST_PAY_L;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAY_P, ST_PAY_L: begin
                if (last_cyc) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A matched request/response pair in one cycle cancels out, so it can neither overflow nor underflow.
    always_comb begin
        pending_d = pending_q;
        error_d   = error_q | type_bad;
        if (req_inc && !rsp_done) begin
            if (pending_q == MAX_PEND) begin
                error_d = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end else if (rsp_done && !req_inc) begin
            if (pending_q == '0) begin
                error_d = 1'b1;
            end else begin
                pending_d = pending_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            error_q   <= error_d;
        end
    end

    // Outputs are forced to their reset values while reset is held, even mid-message.
    assign bus.rx_started    = !reset && start_hit;
    assign bus.rx_active     = !reset && (state_q != ST_IDLE);
    assign bus.rx_sbs_valid  = !reset && in_type;
    assign bus.rx_sbs        = (!reset && in_type) ? bus.rx_pins : '0;
    assign bus.rx_data_valid = !reset && in_pay_p;
    assign bus.rx_load_valid = !reset && in_pay_l;
    assign bus.rx_counter    = reset ? '0 : cnt_q;
    assign bus.rx_done       = !reset && done_p;
    assign bus.rx_load_done  = !reset && done_l;
    assign bus.rx_ack        = !reset && ack_hit;
    assign bus.rx_can_issue  = reset || (pending_q < MAX_PEND);
    assign bus.rx_error      = !reset && error_q;

endmodule

// File: tb/tb_rx_unit.sv
// Directed bench for rx_unit: stimulus queues hand-derived per-cycle expectations, a monitor checks strobe cycles.
module tb_rx_unit;
    localparam int IO_BITS = 2;
    localparam int PC      = 8;
    localparam int MAXP    = 3;

    typedef struct packed {
        logic       started;
        logic       active;
        logic       sbs_valid;
        logic [1:0] sbs;
        logic       data_valid;
        logic       load_valid;
        logic [3:0] counter;
        logic       done;
        logic       load_done;
        logic       ack;
        logic       can_issue;
        logic       error;
    } out_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rx_unit_if #(.IO_BITS(IO_BITS), .PAYLOAD_CYCLES(PC)) bus ();

    rx_unit #(
        .IO_BITS(IO_BITS),
        .PAYLOAD_CYCLES(PC),
        .MAX_PENDING(MAXP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    out_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    function automatic out_t sample();
        out_t o;
        o.started    = bus.rx_started;
        o.active     = bus.rx_active;
        o.sbs_valid  = bus.rx_sbs_valid;
        o.sbs        = bus.rx_sbs;
        o.data_valid = bus.rx_data_valid;
        o.load_valid = bus.rx_load_valid;
        o.counter    = bus.rx_counter;
        o.done       = bus.rx_done;
        o.load_done  = bus.rx_load_done;
        o.ack        = bus.rx_ack;
        o.can_issue  = bus.rx_can_issue;
        o.error      = bus.rx_error;
        return o;
    endfunction

    function automatic out_t mk_idle(input logic can, input logic err);
        out_t o;
        o           = '0;
        o.can_issue = can;
        o.error     = err;
        return o;
    endfunction

    task automatic compare(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (st act sv sbs dv lv cnt dn ld ack can err)",
                     name, act, exp);
        end
    endtask

    // Strobe cycles go to the scoreboard; quiet cycles are checked in place.
    task automatic step(input logic [1:0] pins, input logic req, input out_t exp, input string name);
        @(posedge clk);
        #1;
        reset                 = 1'b0;
        bus.rx_pins           = pins;
        bus.tx_request_issued = req;
        if (exp.started || exp.active) begin
            exp_q.push_back(exp);
            name_q.push_back(name);
        end else begin
            @(negedge clk);
            compare(name, sample(), exp);
        end
    endtask

    task automatic idle(input logic req, input logic can, input logic err, input string name);
        step(2'b00, req, mk_idle(can, err), name);
    endtask

    task automatic reset_cycle(input logic [1:0] pins);
        @(posedge clk);
        #1;
        reset                 = 1'b1;
        bus.rx_pins           = pins;
        bus.tx_request_issued = 1'b0;
    endtask

    task automatic do_reset();
        reset_cycle(2'b00);
        reset_cycle(2'b00);
    endtask

    // Start + type + n_pay payload cycles; can/err are the levels expected throughout the message.
    task automatic send_msg(input logic [1:0] start_sym, input logic [1:0] typ, input int n_pay,
                            input logic req_first, input logic req_last,
                            input logic can, input logic err, input string name);
        out_t e;
        e         = mk_idle(can, err);
        e.started = 1'b1;
        step(start_sym, req_first, e, {name, "_start"});
        e           = mk_idle(can, err);
        e.active    = 1'b1;
        e.sbs_valid = 1'b1;
        e.sbs       = typ;
        e.ack       = (typ == 2'b11);
        step(typ, 1'b0, e, {name, "_type"});
        for (int i = 0; i < n_pay; i++) begin
            e            = mk_idle(can, err);
            e.active     = 1'b1;
            e.data_valid = (typ == 2'b01);
            e.load_valid = (typ == 2'b10);
            e.counter    = 4'(i);
            e.done       = (typ == 2'b01) && (i == PC - 1);
            e.load_done  = (typ == 2'b10) && (i == PC - 1);
            step(2'(i % 4), (i == PC - 1) ? req_last : 1'b0, e, {name, "_pay"});
        end
    endtask

    always @(negedge clk) begin
        if (reset !== 1'b1 && (bus.rx_started === 1'b1 || bus.rx_active === 1'b1)) begin
            if (exp_q.size() == 0) begin
                out_t none;
                none = '0;
                compare("unexpected_strobe", sample(), none);
            end else begin
                out_t  e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                compare(n, sample(), e);
            end
        end
    end

    initial begin
        reset                 = 1'b1;
        bus.rx_pins           = '0;
        bus.tx_request_issued = 1'b0;
        do_reset();
        idle(1'b0, 1'b1, 1'b0, "reset_state");

        // Prefetch message with one outstanding request: pending 1 -> 0, no error.
        idle(1'b1, 1'b1, 1'b0, "t1_req");
        send_msg(2'b01, 2'b01, PC, 1'b0, 1'b0, 1'b1, 1'b0, "t1_pref");
        idle(1'b0, 1'b1, 1'b0, "t1_after");

        // Load message then a write ack with no gap between them.
        idle(1'b1, 1'b1, 1'b0, "t2_req_a");
        idle(1'b1, 1'b1, 1'b0, "t2_req_b");
        send_msg(2'b01, 2'b10, PC, 1'b0, 1'b0, 1'b1, 1'b0, "t2_load");
        send_msg(2'b11, 2'b11, 0, 1'b0, 1'b0, 1'b1, 1'b0, "t2_ack");
        idle(1'b0, 1'b1, 1'b0, "t2_after");

        // Fill to MAX_PENDING, overflow pulse, then an ack frees one slot.
        idle(1'b1, 1'b1, 1'b0, "t3_req1");
        idle(1'b1, 1'b1, 1'b0, "t3_req2");
        idle(1'b1, 1'b1, 1'b0, "t3_req3");
        idle(1'b1, 1'b0, 1'b0, "t3_req4_full");
        idle(1'b0, 1'b0, 1'b1, "t3_overflow");
        send_msg(2'b10, 2'b11, 0, 1'b0, 1'b0, 1'b0, 1'b1, "t3_ack");
        idle(1'b0, 1'b1, 1'b1, "t3_after_ack");
        do_reset();
        idle(1'b0, 1'b1, 1'b0, "t3_reset_clears");

        // Request coincident with rx_done keeps pending at 1; two more requests reach the limit.
        idle(1'b1, 1'b1, 1'b0, "t4_req");
        send_msg(2'b11, 2'b01, PC, 1'b0, 1'b1, 1'b1, 1'b0, "t4_pref");
        idle(1'b0, 1'b1, 1'b0, "t4_after");
        idle(1'b1, 1'b1, 1'b0, "t4_req2");
        idle(1'b1, 1'b1, 1'b0, "t4_req3");
        idle(1'b0, 1'b0, 1'b0, "t4_full");
        do_reset();

        // Bad type symbol, then a response with nothing outstanding.
        send_msg(2'b01, 2'b00, 0, 1'b0, 1'b0, 1'b1, 1'b0, "t5_bad_type");
        idle(1'b0, 1'b1, 1'b1, "t5_err_set");
        do_reset();
        idle(1'b0, 1'b1, 1'b0, "t5_reset_a");
        send_msg(2'b01, 2'b01, PC, 1'b0, 1'b0, 1'b1, 1'b0, "t5_orphan");
        idle(1'b0, 1'b1, 1'b1, "t5_orphan_err");
        idle(1'b0, 1'b1, 1'b1, "t5_err_sticky");
        do_reset();
        idle(1'b0, 1'b1, 1'b0, "t5_reset_b");

        // Reset lands on payload cycle 4; a start follows immediately after.
        idle(1'b1, 1'b1, 1'b0, "t6_req1");
        idle(1'b1, 1'b1, 1'b0, "t6_req2");
        idle(1'b1, 1'b1, 1'b0, "t6_req3");
        send_msg(2'b01, 2'b01, 4, 1'b0, 1'b0, 1'b0, 1'b0, "t6_partial");
        reset_cycle(2'b11);
        send_msg(2'b10, 2'b01, PC, 1'b1, 1'b0, 1'b1, 1'b0, "t6_new");
        idle(1'b0, 1'b1, 1'b0, "t6_after");
        idle(1'b0, 1'b1, 1'b0, "t6_quiet");

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes: %0d expected strobe cycles never seen, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
